// File: rtl/cvxif_dot4_copro.sv
// CV-X-IF coprocessor: int8 SIMD dot product (SDOT4), dot-accumulate (MACC4)
// and accumulator read-and-clear (RDACC) on the custom-0 opcode.
// One instruction in flight; a 32-bit accumulator updates only on the
// result handshake of a committed instruction.
module cvxif_dot4_copro #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned X_ID_WIDTH = 3,
    parameter logic [6:0]  OPCODE     = 7'b0001011
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [XLEN-1:0]       issue_rs1_i,
    input  logic [XLEN-1:0]       issue_rs2_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    output logic                  issue_accept_o,
    output logic                  issue_writeback_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [4:0]            result_rd_o,
    output logic [XLEN-1:0]       result_data_o,
    output logic                  result_we_o
);

    typedef enum logic [2:0] {StIdle, StMul, StSum, StWaitCmt, StResp} state_e;

    localparam logic [2:0] F3Sdot4 = 3'b000;
    localparam logic [2:0] F3Macc4 = 3'b001;
    localparam logic [2:0] F3Rdacc = 3'b010;

    state_e                  state_q, state_d;
    logic                    cmt_q, cmt_d;
    logic [XLEN-1:0]         acc_q, acc_d;
    logic [X_ID_WIDTH-1:0]   id_q;
    logic [4:0]              rd_q;
    logic [2:0]              f3_q;
    logic [XLEN-1:0]         rs1_q, rs2_q;
    logic signed [15:0]      prod_q [4];
    logic signed [15:0]      prod_d [4];
    logic signed [17:0]      dot_q, dot_d;
    logic [XLEN-1:0]         dot_ext;
    logic [XLEN-1:0]         res_data;

    logic       known, issue_hs, accept_hs;
    logic       issue_cmt_match, cmt_match, cmt_ok, kill_hit, res_hs;
    logic [2:0] issue_f3;
    logic       unused_instr;

    // Register-specifier fields of the instruction are supplied as operand values.
    assign unused_instr = ^issue_instr_i[24:15];

    assign issue_f3 = issue_instr_i[14:12];
    assign known    = (issue_instr_i[6:0] == OPCODE) && (issue_instr_i[31:25] == 7'd0) &&
                      ((issue_f3 == F3Sdot4) || (issue_f3 == F3Macc4) || (issue_f3 == F3Rdacc));

    assign issue_cmt_match = commit_valid_i && (commit_id_i == issue_id_i);
    assign cmt_match       = commit_valid_i && (commit_id_i == id_q);
    assign cmt_ok          = cmt_match && !commit_kill_i;
    assign kill_hit        = cmt_match && commit_kill_i;

    // Product lanes and their 18-bit signed sum
    always_comb begin
        dot_d = '0;
        for (int i = 0; i < 4; i++) begin
            prod_d[i] = 16'($signed(rs1_q[8*i +: 8])) * 16'($signed(rs2_q[8*i +: 8]));
            dot_d     = dot_d + 18'(prod_q[i]);
        end
    end

    assign dot_ext = {{(XLEN-18){dot_q[17]}}, dot_q};

    // Writeback value, stable in RESP because acc only moves on the handshake
    always_comb begin
        res_data = '0;
        unique case (f3_q)
            F3Sdot4: res_data = dot_ext;
            F3Macc4: res_data = acc_q + dot_ext;
            F3Rdacc: res_data = acc_q;
            default: res_data = '0;
        endcase
    end

    // Next-state, commit tracking, accumulator update and handshake outputs
    always_comb begin
        state_d        = state_q;
        cmt_d          = cmt_q;
        acc_d          = acc_q;
        issue_ready_o  = 1'b0;
        result_valid_o = 1'b0;
        issue_hs       = 1'b0;
        accept_hs      = 1'b0;
        res_hs         = 1'b0;
        unique case (state_q)
            StIdle: begin
                issue_ready_o = !rst_i;
                issue_hs      = issue_valid_i && issue_ready_o;
                accept_hs     = issue_hs && known;
                cmt_d         = accept_hs && issue_cmt_match && !commit_kill_i;
                // A kill arriving with the issue itself discards the instruction outright
                if (accept_hs && !(issue_cmt_match && commit_kill_i)) state_d = StMul;
            end
            StMul: begin
                cmt_d   = cmt_q || cmt_ok;
                state_d = kill_hit ? StIdle : StSum;
            end
            StSum: begin
                cmt_d = cmt_q || cmt_ok;
                if (kill_hit)               state_d = StIdle;
                else if (cmt_q || cmt_ok)   state_d = StResp;
                else                        state_d = StWaitCmt;
            end
            StWaitCmt: begin
                cmt_d = cmt_ok;
                if (kill_hit)    state_d = StIdle;
                else if (cmt_ok) state_d = StResp;
            end
            StResp: begin
                result_valid_o = 1'b1;
                res_hs         = result_ready_i;
                if (res_hs) begin
                    state_d = StIdle;
                    cmt_d   = 1'b0;
                    if (f3_q == F3Macc4)      acc_d = res_data;
                    else if (f3_q == F3Rdacc) acc_d = '0;
                end else if (kill_hit) begin
                    state_d = StIdle;
                    cmt_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) cmt_d = 1'b0;
    end

    assign issue_accept_o    = accept_hs;
    assign issue_writeback_o = accept_hs;
    assign result_id_o       = result_valid_o ? id_q : '0;
    assign result_rd_o       = result_valid_o ? rd_q : '0;
    assign result_data_o     = result_valid_o ? res_data : '0;
    assign result_we_o       = result_valid_o;

    // Control state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cmt_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cmt_q   <= cmt_d;
            acc_q   <= acc_d;
        end
    end

    // Operand capture and pipelined dot-product datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q  <= '0;
            rd_q  <= '0;
            f3_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            dot_q <= '0;
            for (int i = 0; i < 4; i++) prod_q[i] <= '0;
        end else begin
            if (accept_hs) begin
                id_q  <= issue_id_i;
                rd_q  <= issue_instr_i[11:7];
                f3_q  <= issue_f3;
                rs1_q <= issue_rs1_i;
                rs2_q <= issue_rs2_i;
            end
            if (state_q == StMul) begin
                for (int i = 0; i < 4; i++) prod_q[i] <= prod_d[i];
            end
            if (state_q == StSum) dot_q <= dot_d;
        end
    end

endmodule
